// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the buffered UART transmitter.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_e;

    localparam int UART_TX_MIN_DIV   = 2;
    localparam int UART_TX_DATA_BITS = 8;

endpackage

// File: rtl/didactic_sync_fifo.sv
// Generic single-clock FIFO with occupancy level; push refused when full, pop ignored when empty.
// Latency: pushed word visible at pop_data the cycle after the push; no backpressure beyond full/empty.
module didactic_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk_in,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign level    = count;
    assign pop_data = mem[rd_ptr];

    // A full FIFO refuses the push even when a pop happens on the same edge.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter, LSB first; optional parity bit with UART_TX_PARITY_EN.
// Latency: start bit begins 1 cycle after byte acceptance; back-to-back frames have no idle gap.
// Backpressure: ready_o low while the FIFO is full or in reset; held bytes are never dropped.
module uart_tx_fifo
    import uart_tx_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16
) (
    input  logic                          clk_in,
    input  logic                          reset,
    input  logic [DIV_W-1:0]              cfg_div_i,
    input  logic                          cfg_parity_odd_i,
    input  logic [7:0]                    data_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    output logic                          uart_tx_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          tx_done_o
);

    uart_tx_state_e   state_q, state_d;
    logic [DIV_W-1:0] baud_q, baud_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic [7:0]       fifo_head;
    logic [DIV_W-1:0] eff_div;
    logic             bit_end;

`ifdef UART_TX_PARITY_EN
    logic             par_q, par_d;
`else
    logic             unused_parity_cfg;
    assign unused_parity_cfg = cfg_parity_odd_i;
`endif

    assign ready_o   = !fifo_full && !reset;
    assign busy_o    = (state_q != IDLE) || !fifo_empty;
    assign uart_tx_o = tx_q;
    assign eff_div   = (cfg_div_i < DIV_W'(UART_TX_MIN_DIV)) ? DIV_W'(UART_TX_MIN_DIV) : cfg_div_i;
    assign bit_end   = (baud_q == '0);

    didactic_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_in    (clk_in),
        .reset     (reset),
        .push      (valid_i && ready_o),
        .push_data (data_i),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level_o)
    );

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        div_d     = div_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        fifo_pop  = 1'b0;
        tx_done_o = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d     = par_q;
`endif
        if (state_q != IDLE) begin
            baud_d = bit_end ? (div_q - DIV_W'(1)) : (baud_q - DIV_W'(1));
        end
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_head;
                    div_d    = eff_div;
                    baud_d   = eff_div - DIV_W'(1);
                    tx_d     = 1'b0;
                    state_d  = START;
`ifdef UART_TX_PARITY_EN
                    par_d    = (^fifo_head) ^ cfg_parity_odd_i;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'(UART_TX_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = par_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                        bit_d   = bit_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    tx_done_o = 1'b1;
                    // Chain straight into the next start bit so frames stay contiguous.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_head;
                        div_d    = eff_div;
                        baud_d   = eff_div - DIV_W'(1);
                        tx_d     = 1'b0;
                        state_d  = START;
`ifdef UART_TX_PARITY_EN
                        par_d    = (^fifo_head) ^ cfg_parity_odd_i;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            div_q   <= DIV_W'(UART_TX_MIN_DIV);
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered UART transmitter that drives the SoC `uart_tx` pad. Software or the peripheral bus pushes bytes through a valid/ready port; the block queues them in a small synchronous FIFO and serialises them as 8N1 frames, LSB first, at a runtime-programmable bit period. It is the stage directly upstream of the off-chip UART receiver and of the testbench UART monitor, and it carries all SoC console and status output.

## Interface
- `FIFO_DEPTH`, default 8: byte entries; power of two, minimum 2.
- `DIV_W`, default 16: width of the bit-period divider.
- `clk_in` in 1: system clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `cfg_div_i` in DIV_W: clock cycles per UART bit. Example: 868 gives 115200 baud at 100 MHz.
- `cfg_parity_odd_i` in 1: parity select; used only with `UART_TX_PARITY_EN`.
- `data_i` in 8: byte to transmit.
- `valid_i` in 1: `data_i` is valid.
- `ready_o` out 1: FIFO can accept a byte.
- `uart_tx_o` out 1: serial line; idle high.
- `busy_o` out 1: a frame is in progress or the FIFO is non-empty.
- `fifo_level_o` out $clog2(FIFO_DEPTH)+1: number of queued bytes.
- `tx_done_o` out 1: one-cycle pulse at the end of each stop bit.

## Operation
- Push: a byte is accepted on an edge where `valid_i && ready_o`. `ready_o` = !full && !reset.
- Full FIFO: a push is refused, even if a pop occurs on the same edge. `valid_i` while full is held off; the byte is not dropped.
- FSM states: IDLE → START → DATA → [PARITY] → STOP → IDLE, or STOP → START when the FIFO is non-empty.
- IDLE: when the FIFO is non-empty, pop the head into the shift register, latch the effective divider, and enter START.
- START: drive 0 for one bit period.
- DATA: drive 8 bits LSB first, one bit period each, using a 3-bit bit counter.
- PARITY (macro only): drive the parity bit for one bit period.
- STOP: drive 1 for one bit period, then pulse `tx_done_o`. If the FIFO is non-empty, go directly to START with no idle gap and pop the next byte on the same edge; otherwise go to IDLE.
- Effective divider = max(`cfg_div_i`, 2). A `cfg_div_i` of 0 or 1 is treated as 2.
- The divider is latched at frame start. Changes to `cfg_div_i` mid-frame take effect on the next frame.
- Baud counter counts from div-1 down to 0; it reloads and advances the bit on reaching 0.
- Simultaneous push and pop on a non-full FIFO: both take effect and the level is unchanged.
- Pointers wrap modulo FIFO_DEPTH. An extra level bit distinguishes full from empty.

## Timing
- Reset values: `uart_tx_o`=1, `ready_o`=0, `busy_o`=0, `fifo_level_o`=0, `tx_done_o`=0, FSM=IDLE.
- One edge after `reset` deasserts, `ready_o`=1.
- Reset mid-frame: on the next edge the line goes high and the FIFO is flushed; no partial frame is completed.
- Latency, empty FIFO and IDLE: byte accepted on edge N; FIFO non-empty at N; pop on N+1; `uart_tx_o` falls on edge N+1 (registered output). The start bit begins exactly 1 cycle after acceptance.
- Frame length is exactly 10×div cycles, or 11×div with parity.
- Back-to-back frames are contiguous: the stop bit of frame k is followed immediately by the start bit of frame k+1.
- `tx_done_o` is asserted in the last cycle of the stop bit.
- `busy_o` deasserts in the cycle after `tx_done_o` if the FIFO is empty.
- `uart_tx_o` is driven from a flop with no combinational path to the pad.

## Configuration
- `UART_TX_PARITY_EN` defined: PARITY state is present.
  - Parity bit = XOR of the data bits, inverted when `cfg_parity_odd_i`=1 (even/odd).
  - Frame is 11 bit periods.
- `UART_TX_PARITY_EN` undefined: no PARITY state; `cfg_parity_odd_i` is ignored; frame is 10 bit periods.

## Structure
- `uart_tx_pkg` holds:
  - `uart_tx_state_e` (IDLE, START, DATA, PARITY, STOP);
  - `UART_TX_MIN_DIV`=2;
  - `UART_TX_DATA_BITS`=8.
- Sub-module `didactic_sync_fifo`:
  - parameterised width and depth; single clock; synchronous active-high `reset`;
  - push/pop/full/empty/level ports;
  - reusable by the SPI and GPIO blocks.
- The top level contains the FSM, baud counter, bit counter, shift register and parity flop.

## Test plan
- div=868, push 0x38:
  - line low 1 cycle after acceptance;
  - bit sequence 0,0,0,0,1,1,1,0,0,1;
  - each bit 868 cycles; `tx_done_o` at cycle 8680.
- div=4, push 0x55, 0xA3, 0xFF back-to-back: three contiguous frames of 40 cycles each with no idle gap; three `tx_done_o` pulses 40 cycles apart.
- FIFO full, div=1000:
  - push 9 bytes while the first frame is in progress;
  - `ready_o` drops after the 9th acceptance (1 in shift register + 8 in FIFO);
  - 10th byte held until the first pop; all bytes emitted in order.
- div=0 and div=1: bit period is 2 cycles; frame of 0x00 lasts 20 cycles.
- Reset asserted during bit 3 of a 5-byte burst:
  - `uart_tx_o`=1 and `fifo_level_o`=0 on the next edge;
  - no further frames;
  - `ready_o` returns 1 edge after deassert.
- With `UART_TX_PARITY_EN`, push 0x38 (three ones):
  - `cfg_parity_odd_i`=0 gives parity bit 1;
  - `cfg_parity_odd_i`=1 gives parity bit 0;
  - frame = 11×div.
